spi_mstr_gen: RTL and testbench

//  Parametrised SPI master, successor to the fixed 16-bit master. Full-duplex transfers of DATA_W bits, SPI mode 3
//  (CPOL=1, CPHA=1). Drives up to NUM_SS slave selects. Sits between sensor/command FSMs and off-chip SPI

---
 rtl/spi_mstr_pkg.sv | 13 +
 rtl/spi_sclk_div.sv | 24 ++
 rtl/spi_mstr_gen.sv | 100 ++++++++++
 tb/tb_spi_mstr_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/spi_mstr_pkg.sv
// spi_mstr_pkg: FSM state type and SCLK divider geometry helpers for spi_mstr_gen
package spi_mstr_pkg;
  typedef enum logic [1:0] {IDLE, FRONT, ACTIVE, BACK} state_t;
  function automatic int sclk_p(input int div_w);
    return 1 << div_w;
  endfunction
  function automatic int sclk_h(input int div_w);
    return 1 << (div_w - 1);
  endfunction
  function automatic int sclk_q(input int div_w);
    return 1 << (div_w - 2);
  endfunction
endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: free-running SCLK divider with load, decoding the sample (H-1) and shift (all-ones) points
module spi_sclk_div
  import spi_mstr_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_val,
  output logic             sclk_raw,
  output logic             smpl_pt,
  output logic             shft_pt
);
  logic [DIV_W-1:0] div;
  always_ff @(posedge clk)
    if (rst) div <= '0;
    else if (ld) div <= ld_val;
    else if (en) div <= div + 1'b1;
  assign sclk_raw = div[DIV_W-1];
  assign smpl_pt = div == DIV_W'(sclk_h(DIV_W) - 1);
  assign shft_pt = &div;
endmodule

// File: rtl/spi_mstr_gen.sv
// spi_mstr_gen: parametrised SPI mode-3 master with NUM_SS selects.
// Define SPI_MSTR_LSB_FIRST_EN to add the lsb_first port (LSB-first shifting).
module spi_mstr_gen
  import spi_mstr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 5,
  parameter int NUM_SS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrt,
  input  logic [DATA_W-1:0]       cmd,
  input  logic [$clog2(NUM_SS):0] ss_sel,
`ifdef SPI_MSTR_LSB_FIRST_EN
  input  logic                    lsb_first,
`endif
  input  logic                    MISO,
  output logic                    SCLK,
  output logic                    MOSI,
  output logic [NUM_SS-1:0]       SS_n,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       rd_data
);
  localparam int SS_W = $clog2(NUM_SS) + 1;
  localparam int CW = $clog2(DATA_W + 1);
  state_t state, nxt;
  logic [DATA_W-1:0] sreg, shifted;
  logic [SS_W-1:0] sel;
  logic [CW-1:0] bitcnt;
  logic smpl, accept, full, act, do_smpl, do_shft, sclk_raw, smpl_pt, shft_pt;

  spi_sclk_div #(.DIV_W(DIV_W)) u_div (
    .clk(clk),
    .rst(rst),
    .en(busy),
    .ld(accept),
    .ld_val(DIV_W'(sclk_p(DIV_W) - sclk_q(DIV_W) - 1)),
    .sclk_raw(sclk_raw),
    .smpl_pt(smpl_pt),
    .shft_pt(shft_pt)
  );

  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;

  always_comb
    nxt = state == IDLE   ? (wrt ? FRONT : IDLE) :
          state == FRONT  ? (shft_pt ? ACTIVE : FRONT) :
          state == ACTIVE ? (full ? BACK : ACTIVE) :
                            (shft_pt ? IDLE : BACK);

  always_comb begin
    accept = state == IDLE && wrt;
    busy = state != IDLE;
    act = state == ACTIVE;
    full = bitcnt == CW'(DATA_W);
    SCLK = (state == FRONT || act) ? sclk_raw : 1'b1;
    do_smpl = act && !full && smpl_pt;
    do_shft = ((act && !full) || state == BACK) && shft_pt;
    for (int i = 0; i < NUM_SS; i++) SS_n[i] = !(busy && sel == SS_W'(i));
  end

`ifdef SPI_MSTR_LSB_FIRST_EN
  logic lsb;
  always_ff @(posedge clk)
    lsb <= rst ? 1'b0 : accept ? lsb_first : lsb;
  assign shifted = lsb ? {smpl, sreg[DATA_W-1:1]} : {sreg[DATA_W-2:0], smpl};
  assign MOSI = lsb ? sreg[0] : sreg[DATA_W-1];
`else
  assign shifted = {sreg[DATA_W-2:0], smpl};
  assign MOSI = sreg[DATA_W-1];
`endif

  // the last sampled bit is shifted in from BACK, so done and the full word land together
  always_ff @(posedge clk)
    if (rst) begin
      sreg <= '0;
      sel <= '0;
      smpl <= 1'b0;
      bitcnt <= '0;
      done <= 1'b0;
    end else begin
      if (accept) begin
        sreg <= cmd;
        sel <= ss_sel;
        bitcnt <= '0;
        done <= 1'b0;
      end
      if (do_smpl) begin
        smpl <= MISO;
        bitcnt <= bitcnt + 1'b1;
      end
      if (do_shft) sreg <= shifted;
      if (state == BACK && shft_pt) done <= 1'b1;
    end

  assign rd_data = sreg;
endmodule

// File: tb/tb_spi_mstr_gen.sv
// tb_spi_mstr_gen: scoreboard bench for spi_mstr_gen (NUM_SS=4) with loopback and mode-3 slave model
module tb_spi_mstr_gen;
  logic clk = 1'b0, rst = 1'b1, wrt = 1'b0, lb = 1'b1;
  logic [15:0] cmd = '0, slv_word = '0, sent = '0, mosi_cap = '0, sh, rd_data;
  logic [2:0] ss_sel = '0;
  logic [3:0] ss_exp = 4'hF, SS_n;
  logic MISO, SCLK, MOSI, busy, done;
  int rises = 0, falls = 0, ss_bad = 0, cyc = 0;
  int r0 = 0, f0 = 0, b0 = 0, t0 = 0, checks = 0, errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_mstr_gen #(.DATA_W(16), .DIV_W(5), .NUM_SS(4)) dut (
    .clk(clk),
    .rst(rst),
    .wrt(wrt),
    .cmd(cmd),
    .ss_sel(ss_sel),
`ifdef SPI_MSTR_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .MISO(MISO),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .SS_n(SS_n),
    .busy(busy),
    .done(done),
    .rd_data(rd_data)
  );

  // mode-3 slave: the k-th SCLK fall of a transfer presents slv_word bit 16-k
  assign sh = slv_word >> (16 - (falls - f0));
  assign MISO = lb ? MOSI : sh[0];
  always @(negedge SCLK) falls++;
  always @(posedge SCLK) begin
    rises++;
    mosi_cap <= {mosi_cap[14:0], MOSI};
    if (SS_n !== ss_exp) ss_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] c, input logic [2:0] s, input logic loop, input logic [15:0] w);
    @(negedge clk);
    cmd = c;
    sent = c;
    ss_sel = s;
    lb = loop;
    slv_word = w;
    ss_exp = (s < 3'd4) ? ~(4'b1 << s) : 4'hF;
    r0 = rises;
    f0 = falls;
    b0 = ss_bad;
    t0 = cyc;
    q.push_back(loop ? 32'(c) : 32'(w));
    wrt = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_done_clr", 32'(done), 0);
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 2000);
    chk({tag, "_lat"}, 32'(cyc - t0), 522);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ss_idle"}, 32'(SS_n), 'hF);
    chk({tag, "_rd"}, 32'(rd_data), q.size() != 0 ? q.pop_front() : 32'hDEAD_BEEF);
    chk({tag, "_rises"}, 32'(rises - r0), 16);
    chk({tag, "_ss_low"}, 32'(ss_bad - b0), 0);
    chk({tag, "_mosi"}, 32'(mosi_cap), 32'(sent));
  endtask

`ifdef SPI_MSTR_LSB_FIRST_EN
  logic wrt8 = 1'b0, mosi8, sclk8, busy8, done8;
  logic [7:0] cmd8 = '0, rd8, cap8 = '0;
  logic [0:0] ss8;
  spi_mstr_gen #(.DATA_W(8), .DIV_W(3), .NUM_SS(1)) dut8 (
    .clk(clk),
    .rst(rst),
    .wrt(wrt8),
    .cmd(cmd8),
    .ss_sel(1'b0),
    .lsb_first(1'b1),
    .MISO(mosi8),
    .SCLK(sclk8),
    .MOSI(mosi8),
    .SS_n(ss8),
    .busy(busy8),
    .done(done8),
    .rd_data(rd8)
  );
  always @(posedge sclk8) cap8 <= {cap8[6:0], mosi8};
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss", 32'(SS_n), 'hF);
    chk("rst_sclk", 32'(SCLK), 1);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    start(16'hA5C3, 3'd0, 1'b1, 16'h0000);
    wait_done("loop");
    start(16'hFFFF, 3'd2, 1'b0, 16'h1234);
    wait_done("slave");
    start(16'h5A3C, 3'd5, 1'b1, 16'h0000);
    wait_done("ss5");
    start(16'h0F0F, 3'd1, 1'b1, 16'h0000);
    repeat (98) @(negedge clk);
    cmd = 16'hFFFF;
    ss_sel = 3'd3;
    wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    chk("repulse_busy", 32'(busy), 1);
    wait_done("repulse");
    start(16'h3C96, 3'd3, 1'b0, 16'hBEEF);
    wait_done("on_done");
    start(16'h1111, 3'd0, 1'b1, 16'h0000);
    repeat (198) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ss", 32'(SS_n), 'hF);
    chk("abort_sclk", 32'(SCLK), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done), 0);
    start(16'hC0DE, 3'd1, 1'b1, 16'h0000);
    wait_done("post_rst");
`ifdef SPI_MSTR_LSB_FIRST_EN
    @(negedge clk);
    cmd8 = 8'h01;
    t0 = cyc;
    wrt8 = 1'b1;
    @(negedge clk);
    wrt8 = 1'b0;
    for (int n = 0; n < 500 && !done8; n++) begin
      @(posedge clk);
      #1;
    end
    chk("lsb_lat", 32'(cyc - t0), 68);
    chk("lsb_rd", 32'(rd8), 'h01);
    chk("lsb_first_bit", 32'(cap8[7]), 1);
    chk("lsb_mosi", 32'(cap8), 'h80);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
